// File: rtl/videomem_rd_sched.sv
// Frame-buffer read-request scheduler: walks each frame line by line in bursts,
// throttled by pixel-FIFO fill hysteresis and a cap on words in flight.
module videomem_rd_sched #(
   parameter int ADDR_W         = 25,
   parameter int LEVEL_W        = 2,
   parameter int THRESHOLD_HIGH = 3,
   parameter int THRESHOLD_LOW  = 1,
   parameter int BURST_LEN      = 8,
   parameter int LINE_WORDS     = 1280,
   parameter int LINE_NUM       = 720,
   parameter int LINE_STRIDE    = 2048,
   parameter int MAX_BURSTS     = 4,
   localparam int OUT_W         = $clog2(MAX_BURSTS*BURST_LEN+1)
) (
   input  logic               mem_clock,
   input  logic               reset,
   input  logic               enable,
   input  logic               mem_ready,
   input  logic               rdata_valid,
   input  logic [LEVEL_W-1:0] fifo_level,
   input  logic               vsync,
   input  logic [ADDR_W-1:0]  frame_base,
   input  logic               read_req_ack,
   output logic               read_request,
   output logic [ADDR_W-1:0]  read_addr,
   output logic               frame_done,
   output logic               late_frame,
   output logic [OUT_W-1:0]   outstanding
);
   localparam int BURSTS_PER_LINE = LINE_WORDS / BURST_LEN;
   localparam int BURST_CW        = (BURSTS_PER_LINE > 1) ? $clog2(BURSTS_PER_LINE) : 1;
   localparam int LINE_CW         = (LINE_NUM > 1) ? $clog2(LINE_NUM) : 1;
   localparam int MAX_WORDS       = MAX_BURSTS * BURST_LEN;

   typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

   state_t              state_q, state_d;
   logic                vs_meta_q, vs_meta_d;
   logic                vs_sync_q, vs_sync_d;
   logic                vs_hist_q, vs_hist_d;
   logic                feed_q, feed_d;
   logic                read_request_q, read_request_d;
   logic [ADDR_W-1:0]   read_addr_q, read_addr_d;
   logic [ADDR_W-1:0]   line_start_q, line_start_d;
   logic [BURST_CW-1:0] burst_q, burst_d;
   logic [LINE_CW-1:0]  line_q, line_d;
   logic                frame_done_q, frame_done_d;
   logic                late_frame_q, late_frame_d;
   logic [OUT_W-1:0]    outstanding_q, outstanding_d;

   logic                vs_event;
   logic                accept;
   logic                last_burst;
   logic                last_line;
   logic [OUT_W:0]      out_sum;
   logic                room;

   always_ff @(posedge mem_clock or posedge reset) begin
      if (reset) begin
         state_q        <= IDLE;
         vs_meta_q      <= 1'b0;
         vs_sync_q      <= 1'b0;
         vs_hist_q      <= 1'b0;
         feed_q         <= 1'b0;
         read_request_q <= 1'b0;
         read_addr_q    <= '0;
         line_start_q   <= '0;
         burst_q        <= '0;
         line_q         <= '0;
         frame_done_q   <= 1'b0;
         late_frame_q   <= 1'b0;
         outstanding_q  <= '0;
      end else begin
         state_q        <= state_d;
         vs_meta_q      <= vs_meta_d;
         vs_sync_q      <= vs_sync_d;
         vs_hist_q      <= vs_hist_d;
         feed_q         <= feed_d;
         read_request_q <= read_request_d;
         read_addr_q    <= read_addr_d;
         line_start_q   <= line_start_d;
         burst_q        <= burst_d;
         line_q         <= line_d;
         frame_done_q   <= frame_done_d;
         late_frame_q   <= late_frame_d;
         outstanding_q  <= outstanding_d;
      end
   end

   always_comb begin
      vs_meta_d      = vsync;
      vs_sync_d      = vs_meta_q;
      vs_hist_d      = vs_sync_q;
      state_d        = state_q;
      read_request_d = read_request_q;
      read_addr_d    = read_addr_q;
      line_start_d   = line_start_q;
      burst_d        = burst_q;
      line_d         = line_q;
      frame_done_d   = 1'b0;
      late_frame_d   = late_frame_q;
      feed_d         = feed_q;

      vs_event   = vs_hist_q & ~vs_sync_q;
      accept     = read_request_q & read_req_ack;
      last_burst = (burst_q == BURST_CW'(BURSTS_PER_LINE-1));
      last_line  = (line_q == LINE_CW'(LINE_NUM-1));
      out_sum    = {1'b0, outstanding_q} + (OUT_W+1)'(BURST_LEN);
      room       = (out_sum <= (OUT_W+1)'(MAX_WORDS));

      if (fifo_level <= LEVEL_W'(THRESHOLD_LOW)) begin
         feed_d = 1'b1;
      end else if (fifo_level >= LEVEL_W'(THRESHOLD_HIGH)) begin
         feed_d = 1'b0;
      end

      // An accepted burst is counted even when a vsync restart swallows it.
      outstanding_d = outstanding_q;
      if (accept) begin
         outstanding_d = outstanding_d + OUT_W'(BURST_LEN);
      end
      if (rdata_valid && (outstanding_q != '0)) begin
         outstanding_d = outstanding_d - OUT_W'(1);
      end

      if (vs_event) begin
         if (state_q == ACTIVE) begin
            late_frame_d = 1'b1;
         end
         state_d        = ACTIVE;
         read_request_d = 1'b0;
         line_start_d   = frame_base;
         read_addr_d    = frame_base;
         burst_d        = '0;
         line_d         = '0;
      end else if (accept) begin
         read_request_d = 1'b0;
         if (last_burst) begin
            burst_d      = '0;
            line_d       = line_q + LINE_CW'(1);
            line_start_d = line_start_q + ADDR_W'(LINE_STRIDE);
            read_addr_d  = line_start_q + ADDR_W'(LINE_STRIDE);
            if (last_line) begin
               state_d      = DONE;
               frame_done_d = 1'b1;
            end
         end else begin
            burst_d     = burst_q + BURST_CW'(1);
            read_addr_d = read_addr_q + ADDR_W'(BURST_LEN);
         end
      end else if (!read_request_q && (state_q == ACTIVE) && enable && mem_ready
                   && feed_q && room) begin
         read_request_d = 1'b1;
      end
   end

   assign read_request = read_request_q;
   assign read_addr    = read_addr_q;
   assign frame_done   = frame_done_q;
   assign late_frame   = late_frame_q;
   assign outstanding  = outstanding_q;

endmodule
